// File: rtl/dkong_snd_rom_arb_if.sv
// Byte-wide read port between the sound ROM arbiter and the shared memory bridge.
interface dkong_snd_rom_arb_if;
    logic [19:0] O_MEM_A;
    logic        O_MEM_RD;
    logic [7:0]  I_MEM_D;
    logic        I_MEM_DV;

    modport master (output O_MEM_A, output O_MEM_RD, input I_MEM_D, input I_MEM_DV);
    modport slave  (input O_MEM_A, input O_MEM_RD, output I_MEM_D, output I_MEM_DV);
endinterface

// File: rtl/dkong_snd_rom_arb.sv
// Shares one byte-wide ROM read port between the I8035 program fetch and the wav fetch,
// keeping a one-byte tagged cache per requester.
module dkong_snd_rom_arb #(
    parameter logic [19:0] CPU_BASE = 20'h80000,
    parameter logic [19:0] WAV_BASE = 20'h00000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    input  logic [11:0]         I_CPU_A,
    output logic [7:0]          O_CPU_D,
    output logic                O_CPU_VALID,
    input  logic [18:0]         I_WAV_A,
    output logic [7:0]          O_WAV_D,
    output logic                O_WAV_VALID,
    dkong_snd_rom_arb_if.master mem,
    output logic                O_ERR
);
    typedef enum logic [1:0] {S_IDLE, S_CPU_WAIT, S_WAV_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_cpu_tag;
    logic [18:0] r_wav_tag;
    logic        r_cpu_tv;
    logic        r_wav_tv;
    logic [7:0]  r_cpu_d;
    logic [7:0]  r_wav_d;
    logic        r_last_wav;
    logic [7:0]  r_timer;
    logic [19:0] r_mem_a;
    logic        r_mem_rd;
    logic        r_err;

    logic        w_cpu_valid;
    logic        w_wav_valid;
    logic        w_cpu_pend;
    logic        w_wav_pend;
    logic        w_grant_cpu;
    logic        w_grant_wav;
    logic        w_done;
    logic        w_timeout;

    // The cached byte only counts while the live address still matches its tag.
    assign w_cpu_valid = r_cpu_tv && (r_cpu_tag == I_CPU_A);
    assign w_wav_valid = r_wav_tv && (r_wav_tag == I_WAV_A);
    assign w_cpu_pend  = !w_cpu_valid && (r_state != S_CPU_WAIT);
    assign w_wav_pend  = !w_wav_valid && (r_state != S_WAV_WAIT);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        w_next_state = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_wav  = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_pend && (!w_wav_pend || r_last_wav)) begin
                    w_grant_cpu  = 1'b1;
                    w_next_state = S_CPU_WAIT;
                end else if (w_wav_pend) begin
                    w_grant_wav  = 1'b1;
                    w_next_state = S_WAV_WAIT;
                end
            end
            S_CPU_WAIT, S_WAV_WAIT: begin
                if (mem.I_MEM_DV) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_timer == TIMEOUT_W) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (I_RST) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_cpu_tag  <= '0;
            r_wav_tag  <= '0;
            r_cpu_tv   <= 1'b0;
            r_wav_tv   <= 1'b0;
            r_cpu_d    <= 8'h00;
            r_wav_d    <= 8'h80;
            r_last_wav <= 1'b1;
            r_timer    <= 8'd0;
            r_mem_a    <= '0;
            r_mem_rd   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_rd <= w_grant_cpu || w_grant_wav;
            if (w_grant_cpu) begin
                r_mem_a   <= CPU_BASE + {8'h00, I_CPU_A};
                r_cpu_tag <= I_CPU_A;
                r_cpu_tv  <= 1'b0;
            end
            if (w_grant_wav) begin
                r_mem_a   <= WAV_BASE + {1'b0, I_WAV_A};
                r_wav_tag <= I_WAV_A;
                r_wav_tv  <= 1'b0;
            end
            // Counter starts at 1 in the strobe cycle, so the state leaves WAIT TIMEOUT cycles later.
            if (w_grant_cpu || w_grant_wav) r_timer <= 8'd1;
            else if (r_state != S_IDLE)      r_timer <= r_timer + 8'd1;
            // Data lands even if the address moved on; the tag compare then reports a miss.
            if (w_done) begin
                if (r_state == S_CPU_WAIT) begin
                    r_cpu_d  <= mem.I_MEM_D;
                    r_cpu_tv <= 1'b1;
                end else begin
                    r_wav_d  <= mem.I_MEM_D;
                    r_wav_tv <= 1'b1;
                end
            end
            if (w_done || w_timeout) r_last_wav <= (r_state == S_WAV_WAIT);
            if (w_timeout)           r_err      <= 1'b1;
        end
    end

    assign O_CPU_D      = r_cpu_d;
    assign O_CPU_VALID  = w_cpu_valid;
    assign O_WAV_D      = r_wav_d;
    assign O_WAV_VALID  = w_wav_valid;
    assign mem.O_MEM_A  = r_mem_a;
    assign mem.O_MEM_RD = r_mem_rd;
    assign O_ERR        = r_err;
endmodule

// File: tb/tb_dkong_snd_rom_arb.sv
// Self-checking bench for dkong_snd_rom_arb: read addresses go through a scoreboard queue,
// a behavioural memory answers reads, and each scenario task checks its own outputs.
module tb_dkong_snd_rom_arb;
    localparam logic [19:0] CPU_BASE = 20'h80000;
    localparam logic [19:0] WAV_BASE = 20'h00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cpu_a = '0;
    logic [7:0]  cpu_d;
    logic        cpu_valid;
    logic [18:0] wav_a = '0;
    logic [7:0]  wav_d;
    logic        wav_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_addr_q[$];
    logic [19:0] mon_exp;
    logic [7:0]  cpu_exp = 8'h00;
    logic [7:0]  wav_exp = 8'h80;

    // Memory model controls.
    bit          resp_en   = 1'b0;
    int          lat       = 1;
    bit          use_fixed = 1'b0;
    logic [7:0]  fixed_d   = 8'h00;
    int          stray_cnt = 0;

    dkong_snd_rom_arb_if mem_if();

    dkong_snd_rom_arb #(
        .CPU_BASE(CPU_BASE),
        .WAV_BASE(WAV_BASE),
        .TIMEOUT (4)
    ) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_CPU_A    (cpu_a),
        .O_CPU_D    (cpu_d),
        .O_CPU_VALID(cpu_valid),
        .I_WAV_A    (wav_a),
        .O_WAV_D    (wav_d),
        .O_WAV_VALID(wav_valid),
        .mem        (mem_if.master),
        .O_ERR      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_byte(input logic [19:0] a);
        return a[7:0] ^ {a[19:16], a[11:8]} ^ 8'h3C;
    endfunction

    // Scoreboard: every read strobe must match the next expected address.
    always @(negedge clk) begin
        if (mem_if.O_MEM_RD === 1'b1) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL mem_rd_unexpected: got read at %h, required no read", mem_if.O_MEM_A);
            end else begin
                mon_exp = exp_addr_q.pop_front();
                if (mem_if.O_MEM_A !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_rd_addr: got %h, required %h", mem_if.O_MEM_A, mon_exp);
                end
            end
        end
    end

    // Memory responder: answers a strobe with DV 'lat' cycles later; can inject a stray DV.
    initial begin
        bit         busy;
        int         cnt;
        int         stray_seen;
        logic [7:0] rdata;
        busy = 1'b0;
        cnt = 0;
        stray_seen = 0;
        rdata = 8'h00;
        mem_if.I_MEM_DV = 1'b0;
        mem_if.I_MEM_D  = 8'h00;
        forever begin
            @(negedge clk);
            mem_if.I_MEM_DV = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                mem_if.I_MEM_DV = 1'b1;
                mem_if.I_MEM_D  = 8'hEE;
            end
            if (mem_if.O_MEM_RD === 1'b1 && resp_en) begin
                busy  = 1'b1;
                cnt   = lat;
                rdata = use_fixed ? fixed_d : model_byte(mem_if.O_MEM_A);
            end
            if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0;
                    mem_if.I_MEM_DV = 1'b1;
                    mem_if.I_MEM_D  = rdata;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic wait_rd(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (mem_if.O_MEM_RD === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_both_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cpu_valid === 1'b1 && wav_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cpu_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cpu_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        rst = 1'b1; cpu_a = 12'h000; wav_a = 19'h0; resp_en = 1'b1; lat = 1; use_fixed = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wav_d !== 8'h80) begin errors++; $display("FAIL rst_wav_d: got %h, required 80", wav_d); end
        checks++; if (cpu_d !== 8'h00) begin errors++; $display("FAIL rst_cpu_d: got %h, required 00", cpu_d); end
        checks++; if (cpu_valid !== 1'b0 || wav_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got cpu %b wav %b, required 0 0", cpu_valid, wav_valid);
        end
        checks++; if (mem_if.O_MEM_RD !== 1'b0 || mem_if.O_MEM_A !== 20'h0) begin
            errors++; $display("FAIL rst_mem: got rd %b a %h, required 0 00000", mem_if.O_MEM_RD, mem_if.O_MEM_A);
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", err); end
        exp_addr_q.push_back(CPU_BASE);
        exp_addr_q.push_back(WAV_BASE);
        rst = 1'b0;
        wait_both_valid(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_fill_timeout: got no valid pair, required both valid"); end
        cpu_exp = model_byte(CPU_BASE);
        wav_exp = model_byte(WAV_BASE);
        checks++; if (cpu_d !== cpu_exp) begin errors++; $display("FAIL rst_fill_cpu_d: got %h, required %h", cpu_d, cpu_exp); end
        checks++; if (wav_d !== wav_exp) begin errors++; $display("FAIL rst_fill_wav_d: got %h, required %h", wav_d, wav_exp); end
    endtask

    task automatic test_cpu_miss;
        lat = 3; use_fixed = 1'b1; fixed_d = 8'h5A;
        @(negedge clk);
        cpu_a = 12'h123;
        exp_addr_q.push_back(20'h80123);
        #1;
        checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL miss_valid_drop: got %b, required 0", cpu_valid); end
        @(negedge clk);
        checks++; if (mem_if.O_MEM_RD !== 1'b1 || mem_if.O_MEM_A !== 20'h80123) begin
            errors++; $display("FAIL miss_rd: got rd %b a %h, required 1 80123", mem_if.O_MEM_RD, mem_if.O_MEM_A);
        end
        repeat (3) @(negedge clk);
        checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL miss_valid_early: got %b, required 0", cpu_valid); end
        @(negedge clk);
        checks++; if (cpu_valid !== 1'b1 || cpu_d !== 8'h5A) begin
            errors++; $display("FAIL miss_data: got valid %b d %h, required 1 5a", cpu_valid, cpu_d);
        end
        checks++; if (wav_valid !== 1'b1 || mem_if.O_MEM_A !== 20'h80123) begin
            errors++; $display("FAIL miss_hold: got wav_valid %b a %h, required 1 80123", wav_valid, mem_if.O_MEM_A);
        end
        cpu_exp = 8'h5A;
        use_fixed = 1'b0;
    endtask

    // Last grant was CPU, so each simultaneous double miss must be served WAV then CPU.
    task automatic test_back_to_back;
        bit ok;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_a = 12'h200 + 12'(i * 3);
            wav_a = 19'h10000 + 19'(i * 17);
            exp_addr_q.push_back(WAV_BASE + {1'b0, wav_a});
            exp_addr_q.push_back(CPU_BASE + {8'h00, cpu_a});
            cpu_exp = model_byte(CPU_BASE + {8'h00, cpu_a});
            wav_exp = model_byte(WAV_BASE + {1'b0, wav_a});
            wait_both_valid(40, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout[%0d]: got no valid pair, required both valid", i); end
            checks++; if (cpu_d !== cpu_exp || wav_d !== wav_exp) begin
                errors++; $display("FAIL b2b_data[%0d]: got cpu %h wav %h, required cpu %h wav %h", i, cpu_d, wav_d, cpu_exp, wav_exp);
            end
        end
    endtask

    task automatic test_addr_change;
        bit ok;
        lat = 3;
        @(negedge clk);
        cpu_a = 12'h010;
        exp_addr_q.push_back(20'h80010);
        wait_rd(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chg_rd_timeout: got no read, required read"); end
        @(negedge clk);
        cpu_a = 12'h011;
        exp_addr_q.push_back(20'h80011);
        repeat (3) @(negedge clk);
        checks++; if (cpu_valid !== 1'b0 || cpu_d !== model_byte(20'h80010)) begin
            errors++; $display("FAIL chg_stale: got valid %b d %h, required 0 %h", cpu_valid, cpu_d, model_byte(20'h80010));
        end
        wait_cpu_valid(20, ok);
        cpu_exp = model_byte(20'h80011);
        checks++; if (!ok || cpu_d !== cpu_exp) begin
            errors++; $display("FAIL chg_refetch: got valid %b d %h, required 1 %h", ok, cpu_d, cpu_exp);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pre: got %b, required 0", err); end
        resp_en = 1'b0;
        @(negedge clk);
        cpu_a = 12'h3AB;
        exp_addr_q.push_back(20'h803AB);
        exp_addr_q.push_back(20'h803AB);
        wait_rd(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_rd_timeout: got no read, required read"); end
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b, required 0", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1 || mem_if.O_MEM_RD !== 1'b0) begin
            errors++; $display("FAIL to_expire: got err %b rd %b, required 1 0", err, mem_if.O_MEM_RD);
        end
        resp_en = 1'b1;
        @(negedge clk);
        checks++; if (mem_if.O_MEM_RD !== 1'b1) begin errors++; $display("FAIL to_reissue: got rd %b, required 1", mem_if.O_MEM_RD); end
        wait_cpu_valid(20, ok);
        cpu_exp = model_byte(20'h803AB);
        checks++; if (!ok || cpu_d !== cpu_exp || err !== 1'b1) begin
            errors++; $display("FAIL to_recover: got valid %b d %h err %b, required 1 %h 1", ok, cpu_d, err, cpu_exp);
        end
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        lat = 3;
        @(negedge clk);
        stray_cnt++;
        repeat (3) @(negedge clk);
        checks++; if (cpu_d !== cpu_exp || wav_d !== wav_exp || cpu_valid !== 1'b1 || wav_valid !== 1'b1) begin
            errors++; $display("FAIL stray_dv_idle: got cpu %h wav %h valid %b%b, required %h %h 11", cpu_d, wav_d, cpu_valid, wav_valid, cpu_exp, wav_exp);
        end
        @(negedge clk);
        wav_a = 19'h45678;
        exp_addr_q.push_back(WAV_BASE + 20'h45678);
        wait_rd(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmr_rd_timeout: got no read, required read"); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wav_d !== 8'h80 || wav_valid !== 1'b0 || cpu_valid !== 1'b0) begin
            errors++; $display("FAIL rmr_state: got wav_d %h valid %b%b, required 80 00", wav_d, cpu_valid, wav_valid);
        end
        checks++; if (err !== 1'b0 || mem_if.O_MEM_RD !== 1'b0) begin
            errors++; $display("FAIL rmr_err_rd: got err %b rd %b, required 0 0", err, mem_if.O_MEM_RD);
        end
        exp_addr_q.push_back(CPU_BASE + {8'h00, cpu_a});
        exp_addr_q.push_back(WAV_BASE + {1'b0, wav_a});
        cpu_exp = model_byte(CPU_BASE + {8'h00, cpu_a});
        wav_exp = model_byte(WAV_BASE + {1'b0, wav_a});
        rst = 1'b0;
        wait_both_valid(50, ok);
        checks++; if (!ok || cpu_d !== cpu_exp || wav_d !== wav_exp) begin
            errors++; $display("FAIL rmr_refill: got ok %b cpu %h wav %h, required 1 %h %h", ok, cpu_d, wav_d, cpu_exp, wav_exp);
        end
    endtask

    initial begin
        test_reset;
        test_cpu_miss;
        test_back_to_back;
        test_addr_change;
        test_timeout;
        test_reset_mid_read;
        repeat (5) @(negedge clk);
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++; $display("FAIL reads_missing: got %0d outstanding, required 0", exp_addr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
